// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multi-digit 7-segment driver. A binary value captured on a load strobe is
//   converted to BCD by a sequential shift-add-3 engine. The finished digits
//   are then time-multiplexed onto shared active-low segment and anode lines.
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-high reset
//   value     binary number to display (BIN_WIDTH bits)
//   load      single-cycle strobe, captures value
//   busy      conversion in progress
//   overflow  last accepted value >= 10^NUM_DIGITS (every digit shows a dash)
//   seg       segments, active low, bit6=a ... bit0=g
//   an        digit enables, active low, an[0] = rightmost digit
//
// Handshake: load is a fire-and-forget strobe. It is accepted directly while
// busy=0. While busy=1 it is parked in a one-entry pending slot (last strobe
// wins), and the slot is accepted on the cycle after the conversion finishes.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_WIDTH   = 14,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_WIDTH-1:0]  value,
  input  logic                  load,
  output logic                  busy,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int CNT_W = $clog2(BIN_WIDTH);
  localparam logic [31:0] LIMIT = 32'(10 ** NUM_DIGITS);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_scr_q, ovf_scr_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [BIN_WIDTH-1:0] pend_val_q, pend_val_d;
  logic [BCD_W-1:0]     disp_q, disp_d;
  logic                 ovf_q, ovf_d;

  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     bcd_sh;
  logic [BIN_WIDTH-1:0] bin_sh;
  logic [BIN_WIDTH-1:0] acc_val;

  // Shift-add-3 step. Scratch holds only NUM_DIGITS nibbles: carries only move
  // upward, so the displayed digits are exact whenever the value fits, and an
  // oversized value is shown as dashes regardless of the scratch contents.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_sh = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
    bin_sh = {bin_q[BIN_WIDTH-2:0], 1'b0};
  end

  // A fresh strobe beats an older pending value.
  assign acc_val = load ? value : pend_val_q;

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_scr_d  = ovf_scr_q;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (load || pend_vld_q) begin
          state_d    = S_CONV;
          bin_d      = acc_val;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_scr_d  = (32'(acc_val) >= LIMIT);
          pend_vld_d = 1'b0;
        end
      end
      S_CONV: begin
        bin_d = bin_sh;
        bcd_d = bcd_sh;
        cnt_d = cnt_q + 1'b1;
        if (load) begin
          pend_vld_d = 1'b1;
          pend_val_d = value;
        end
        // Last shift: publish digits and overflow together.
        if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
          state_d = S_IDLE;
          disp_d  = bcd_sh;
          ovf_d   = ovf_scr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_scr_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_scr_q  <= ovf_scr_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
    end
  end

  // ---------------------------------------------------------------- scan ---
  logic [REF_W-1:0]      ref_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  scan_on_q;
  logic [6:0]            seg_q, seg_nxt;
  logic [NUM_DIGITS-1:0] an_q, an_nxt;
  logic                  ref_tc;
  logic [NUM_DIGITS-1:0] lz;
  logic [3:0]            cur_nib;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'b0000001;
      4'd1: decode = 7'b1001111;
      4'd2: decode = 7'b0010010;
      4'd3: decode = 7'b0000110;
      4'd4: decode = 7'b1001100;
      4'd5: decode = 7'b0100100;
      4'd6: decode = 7'b0100000;
      4'd7: decode = 7'b0001111;
      4'd8: decode = 7'b0000000;
      4'd9: decode = 7'b0001100;
      default: decode = 7'b1111111;
    endcase
  endfunction

  assign ref_tc = (ref_q == REF_W'(REFRESH_DIV - 1));

  // lz[i] = digit i and every digit above it are zero.
  always_comb begin
    lz = '0;
    lz[NUM_DIGITS-1] = (disp_q[BCD_W-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (disp_q[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    cur_nib = disp_q[4*int'(idx_q) +: 4];
    an_nxt  = ~(NUM_DIGITS'(1) << idx_q);
    if (ovf_q)
      seg_nxt = 7'b1111110;
    else if ((BLANK_LZ != 0) && (idx_q != '0) && lz[idx_q])
      seg_nxt = 7'b1111111;
    else
      seg_nxt = decode(cur_nib);
  end

  // an/seg stay dark until the first index step after reset, then follow the
  // current index (and the current display contents) one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q     <= '0;
      idx_q     <= '0;
      scan_on_q <= 1'b0;
      seg_q     <= 7'b1111111;
      an_q      <= '1;
    end else begin
      if (ref_tc) begin
        ref_q     <= '0;
        idx_q     <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        scan_on_q <= 1'b1;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
      if (scan_on_q) begin
        seg_q <= seg_nxt;
        an_q  <= an_nxt;
      end
    end
  end

  assign busy     = (state_q == S_CONV);
  assign overflow = ovf_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver. Instances: u_a (4 digits, 14 bits,
//   blanking on), u_b (same, blanking off, shares u_a's inputs) and u_c
//   (6 digits, 20 bits). REFRESH_DIV=4 keeps the scan short.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [13:0] value_ab;
  logic        load_ab;
  logic [19:0] value_c;
  logic        load_c;

  logic       busy_a, ovf_a, busy_b, ovf_b, busy_c, ovf_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] an_a, an_b;
  logic [5:0] an_c;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] D0 = 7'b0000001, D1 = 7'b1001111, D2 = 7'b0010010,
                         D3 = 7'b0000110, D4 = 7'b1001100, D7 = 7'b0001111,
                         D9 = 7'b0001100, BLK = 7'b1111111, DASH = 7'b1111110;

  seg7_scan_driver #(.NUM_DIGITS(4), .BIN_WIDTH(14), .REFRESH_DIV(4), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst(rst), .value(value_ab), .load(load_ab),
    .busy(busy_a), .overflow(ovf_a), .seg(seg_a), .an(an_a));

  seg7_scan_driver #(.NUM_DIGITS(4), .BIN_WIDTH(14), .REFRESH_DIV(4), .BLANK_LZ(0)) u_b (
    .clk(clk), .rst(rst), .value(value_ab), .load(load_ab),
    .busy(busy_b), .overflow(ovf_b), .seg(seg_b), .an(an_b));

  seg7_scan_driver #(.NUM_DIGITS(6), .BIN_WIDTH(20), .REFRESH_DIV(4), .BLANK_LZ(1)) u_c (
    .clk(clk), .rst(rst), .value(value_c), .load(load_c),
    .busy(busy_c), .overflow(ovf_c), .seg(seg_c), .an(an_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_load(input int which, input logic [19:0] v);
    @(negedge clk);
    if (which == 0) begin value_ab = v[13:0]; load_ab = 1'b1; end
    else begin value_c = v; load_c = 1'b1; end
    @(negedge clk);
    load_ab = 1'b0;
    load_c  = 1'b0;
  endtask

  // Wait for the conversion to finish, plus one edge so seg reflects it.
  task automatic wait_idle(input int which);
    int n = 0;
    while (((which == 0) ? busy_a : busy_c) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL idle_timeout: observed busy after %0d cycles expected idle", n);
    end
    @(negedge clk);
  endtask

  // Wait until digit d is enabled, then compare its segments.
  task automatic check_digit(input int which, input int d, input string tag,
                             input logic [6:0] exp_seg, input bit chk_b,
                             input logic [6:0] exp_b);
    int n = 0;
    logic [5:0] cur, want;
    want = ~(6'd1 << d);
    cur  = (which == 0) ? {2'b11, an_a} : an_c;
    while (cur !== want && n < 60) begin
      n++;
      @(negedge clk);
      cur = (which == 0) ? {2'b11, an_a} : an_c;
    end
    if (n >= 60) begin
      errors++;
      $display("FAIL %s_an_timeout: observed an %0h expected %0h", tag, cur, want);
    end else begin
      check(tag, (which == 0) ? seg_a : seg_c, exp_seg);
      if (chk_b) check({tag, "_b"}, seg_b, exp_b);
    end
  endtask

  initial begin
    int n;
    int nh;
    int falls;
    logic prev;
    rst = 1'b1; value_ab = '0; load_ab = 1'b0; value_c = '0; load_c = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 1'b0);
    check("rst_ovf", ovf_a, 1'b0);
    check("rst_seg", seg_a, BLK);
    check("rst_an", an_a, 4'hf);
    rst = 1'b0;

    // 1234: busy length and per-digit decode
    do_load(0, 1234);
    n = 0;
    while (busy_a && n < 100) begin n++; @(negedge clk); end
    check("busy_len_1234", n, 14);
    @(negedge clk);
    check("ovf_1234", ovf_a, 1'b0);
    check_digit(0, 0, "1234_d0", D4, 0, BLK);
    check_digit(0, 1, "1234_d1", D3, 0, BLK);
    check_digit(0, 2, "1234_d2", D2, 0, BLK);
    check_digit(0, 3, "1234_d3", D1, 0, BLK);
    check_digit(0, 0, "1234_wrap_d0", D4, 0, BLK);

    // 7: blanking on (u_a) versus off (u_b)
    do_load(0, 7);
    wait_idle(0);
    check_digit(0, 0, "7_d0", D7, 1, D7);
    check_digit(0, 1, "7_d1", BLK, 1, D0);
    check_digit(0, 2, "7_d2", BLK, 1, D0);
    check_digit(0, 3, "7_d3", BLK, 1, D0);

    // 0: only digit 0 lit
    do_load(0, 0);
    wait_idle(0);
    check_digit(0, 0, "0_d0", D0, 0, BLK);
    check_digit(0, 1, "0_d1", BLK, 0, BLK);
    check_digit(0, 3, "0_d3", BLK, 0, BLK);

    // overflow boundary
    do_load(0, 10000);
    wait_idle(0);
    check("ovf_10000", ovf_a, 1'b1);
    check_digit(0, 0, "10000_d0", DASH, 1, DASH);
    check_digit(0, 3, "10000_d3", DASH, 1, DASH);
    do_load(0, 9999);
    wait_idle(0);
    check("ovf_9999", ovf_a, 1'b0);
    check_digit(0, 0, "9999_d0", D9, 0, BLK);
    check_digit(0, 3, "9999_d3", D9, 0, BLK);

    // pending: 55, then 66 and 77 while busy -> 77 displayed, one idle gap
    do_load(0, 55);
    nh = 0; falls = 0; prev = busy_a;
    for (int i = 0; i < 40; i++) begin
      if (busy_a) nh++;
      if (prev && !busy_a) falls++;
      prev = busy_a;
      if (i == 2) begin value_ab = 14'd66; load_ab = 1'b1; end
      if (i == 3) value_ab = 14'd77;
      if (i == 4) load_ab = 1'b0;
      @(negedge clk);
    end
    check("pend_busy_cycles", nh, 28);
    check("pend_busy_falls", falls, 2);
    check_digit(0, 0, "77_d0", D7, 0, BLK);
    check_digit(0, 1, "77_d1", D7, 0, BLK);
    check_digit(0, 2, "77_d2", BLK, 0, BLK);

    // reset in cycle 7 of a conversion
    do_load(0, 1234);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_seg", seg_a, BLK);
    check("midrst_an", an_a, 4'hf);
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_ovf", ovf_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    do_load(0, 42);
    wait_idle(0);
    check_digit(0, 0, "42_d0", D2, 0, BLK);
    check_digit(0, 1, "42_d1", D4, 0, BLK);
    check_digit(0, 2, "42_d2", BLK, 0, BLK);
    check_digit(0, 3, "42_d3", BLK, 0, BLK);

    // six-digit instance
    do_load(1, 999999);
    n = 0;
    while (busy_c && n < 100) begin n++; @(negedge clk); end
    check("busy_len_c", n, 20);
    @(negedge clk);
    check("ovf_999999", ovf_c, 1'b0);
    check_digit(1, 0, "999999_d0", D9, 0, BLK);
    check_digit(1, 5, "999999_d5", D9, 0, BLK);
    check_digit(1, 0, "999999_wrap_d0", D9, 0, BLK);
    do_load(1, 1000000);
    wait_idle(1);
    check("ovf_1000000", ovf_c, 1'b1);
    check_digit(1, 2, "1000000_d2", DASH, 0, BLK);
    check_digit(1, 5, "1000000_d5", DASH, 0, BLK);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multi-digit 7-segment display driver for the Basys 3 whack-a-mole score and timer displays. It accepts a binary value on a load strobe and converts it to BCD with a sequential shift-add-3 (double dabble) engine. It then time-multiplexes the digits onto shared active-low segment and anode lines, with optional leading-zero blanking and an overflow indication. It sits between the game-control FSM and the board's seg/an pins.

Parameters:
NUM_DIGITS, 4, number of displayed digits (legal 1..8)
BIN_WIDTH, 14, width of binary input (legal 4..27)
REFRESH_DIV, 100000, clk cycles each digit is enabled (>=2; 100000 = 1 ms at 100 MHz)
BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
value  input  BIN_WIDTH  binary number to display
load  input  1  single-cycle strobe; capture value
busy  output  1  conversion in progress
overflow  output  1  last accepted value >= 10^NUM_DIGITS
seg  output  7  segments, active low, bit6=a ... bit0=g
an  output  NUM_DIGITS  digit enables, active low, an[0] = rightmost digit

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high (rst).
- Reset values:
  - busy=0, overflow=0, seg=7'b1111111, an=all ones.
  - Display BCD registers=0, refresh counter=0, digit index=0, pending flag=0.
- Load acceptance:
  - load while busy=0 is accepted: value is captured into the shift register, BCD scratch is cleared, busy=1 on the next edge.
  - load while busy=1 stores value in a one-entry pending register. Last strobe wins.
  - When the current conversion finishes, the pending value is accepted on the following cycle.
- Conversion:
  - Exactly BIN_WIDTH shift cycles. Each cycle, every BCD nibble >=5 gets +3, then the whole {bcd,bin} vector shifts left by 1.
  - On the BIN_WIDTH-th shift edge, the display BCD registers are written atomically and busy drops to 0.
  - Latency from the accepting edge to the display update is BIN_WIDTH edges.
  - The display never shows a partially converted value.
- Overflow:
  - Evaluated at capture: overflow=1 if value >= 10^NUM_DIGITS (localparam).
  - overflow is registered together with the display update.
  - While overflow=1, every digit shows a dash, seg=7'b1111110 (g only), and blanking is ignored.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index increments, wrapping NUM_DIGITS-1 -> 0.
  - an and seg are registered and update on the edge after the index changes.
  - Exactly one an bit is low at any time after the first post-reset index update.
- Decode (seg, digit value 0-9):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
  - Any other nibble = 1111111 (unreachable, defined anyway).
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i>0 is blanked (seg=1111111, an bit still driven low) if it and all higher digits are zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Simultaneous events:
  - load on the same edge as conversion completion goes to pending and is accepted next cycle.
  - Display update on the edge a digit is being scanned: seg reflects the new value from the next edge.
- rst asserted mid-conversion aborts the conversion and clears pending. All state returns to reset values immediately (asynchronous).

Test Plan:
- (NUM_DIGITS=4, BIN_WIDTH=14, REFRESH_DIV=4) rst, release, load value=1234 -> busy high exactly 14 cycles; an cycles 1110,1101,1011,0111 every 4 clks; seg = 1001111 (1), 0010010 (2), 0000110 (3), 1001100 (4) on an[3..0] respectively.
- load value=7, BLANK_LZ=1 -> digit0 seg=0001111, digits1-3 seg=1111111; with BLANK_LZ=0, digits1-3 show 0000001. load value=0 -> only digit0 shows 0000001.
- load value=10000 -> overflow=1, all digits seg=1111110; then load 9999 -> overflow=0, all digits 0001100.
- load 55 then load 66 and 77 while busy -> display goes 55 then 77 (66 never shown); busy stays high for 2x14 cycles plus 1 gap cycle.
- Assert rst mid-conversion (cycle 7 of 14) -> seg=1111111, an=1111, busy=0 immediately. Previous display value cleared; next load displays correctly.
- NUM_DIGITS=6, BIN_WIDTH=20, load 999999 -> six digits 0001100, overflow=0; load 1000000 -> dashes, overflow=1; an wraps 5 -> 0.
